// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, instruction opcodes, register
// names and the fetch sequencer state encoding.
package cpu_pkg;

  localparam int CPU_ADDR_W  = 16;
  localparam int CPU_INSTR_W = 16;

  // Instruction word layout: [15:12] opcode, [11:9] rd, [8:6] rs, [5:0] imm/rt
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_LD   = 4'h6,
    OP_ST   = 4'h7,
    OP_ADDI = 4'h8,
    OP_BEQ  = 4'h9,
    OP_BNE  = 4'hA,
    OP_JMP  = 4'hB,
    OP_JAL  = 4'hC,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    R0, R1, R2, R3, R4, R5, R6, R7
  } reg_t;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  function automatic opcode_t instr_opcode(input logic [CPU_INSTR_W-1:0] instr);
    return opcode_t'(instr[15:12]);
  endfunction

  function automatic logic is_halt(input logic [CPU_INSTR_W-1:0] instr);
    return instr[15:12] == OP_HALT;
  endfunction

  // Saturating increment for 16-bit event counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for the IF stage.
// Owns the PC, launches one synchronous read per cycle into the 16-bit
// instruction memory and tags the returning word with its PC and a valid bit.
// Handles stall, redirect (with kill of the in-flight word), halt and
// out-of-range address faults.
// Optional build macro FETCH_PERF_EN adds saturating perf counters
// perf_fetch_o / perf_kill_o / perf_stall_o.
//
// state | meaning
// BOOT  | one idle cycle after reset, no fetch
// RUN   | fetching one word per cycle unless stalled
// HALT  | fetching stopped by HALT; a redirect restarts it
// FAULT | fetch address ran past the implemented memory; reset only
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = CPU_ADDR_W,
  parameter int                INSTR_W   = CPU_INSTR_W,
  parameter int                MEM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               redirect_v_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  input  logic               halt_i,
  output logic [ADDR_W-1:0]  imem_addr_o,
  output logic               imem_en_o,
  output logic               imem_kill_o,
  input  logic [INSTR_W-1:0] imem_instr_i,
  output logic [INSTR_W-1:0] if_instr_o,
  output logic [ADDR_W-1:0]  if_pc_o,
  output logic               if_valid_o,
`ifdef FETCH_PERF_EN
  output logic [15:0]        perf_fetch_o,
  output logic [15:0]        perf_kill_o,
  output logic [15:0]        perf_stall_o,
`endif
  output logic               fault_o
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_v_q, inflight_v_d;
  logic              fault_q, fault_d;
  logic              launch_en;
  logic              kill;
  logic              pc_out_of_range;

  // Widened compare so MEM_DEPTH == 2^ADDR_W never reports a fault.
  assign pc_out_of_range = (33'(pc_q) >= 33'(MEM_DEPTH));

  // State, PC, in-flight tag and sticky fault registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_v_q  <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_v_q  <= inflight_v_d;
      fault_q       <= fault_d;
    end
  end

  // Next-state and per-cycle memory control; redirect outranks halt and stall.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_v_d  = inflight_v_q;
    fault_d       = fault_q;
    launch_en     = 1'b0;
    kill          = 1'b0;

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end

      RUN: begin
        if (redirect_v_i) begin
          kill         = 1'b1;
          pc_d         = redirect_pc_i;
          inflight_v_d = 1'b0;
        end else if (halt_i) begin
          inflight_v_d = 1'b0;
          state_d      = HALT;
        end else if (stall_i) begin
          // Hold everything; the memory keeps presenting the last word.
        end else if (pc_out_of_range) begin
          fault_d      = 1'b1;
          inflight_v_d = 1'b0;
          state_d      = FAULT;
        end else begin
          launch_en     = 1'b1;
          inflight_pc_d = pc_q;
          inflight_v_d  = 1'b1;
          pc_d          = pc_q + ADDR_W'(1);
        end
      end

      HALT: begin
        if (redirect_v_i) begin
          kill         = 1'b1;
          pc_d         = redirect_pc_i;
          inflight_v_d = 1'b0;
          state_d      = RUN;
        end
      end

      FAULT: begin
        inflight_v_d = 1'b0;
      end

      default: begin
        state_d      = BOOT;
        inflight_v_d = 1'b0;
      end
    endcase
  end

  assign imem_addr_o = pc_q;
  assign imem_en_o   = launch_en;
  assign imem_kill_o = kill;
  assign if_instr_o  = imem_instr_i;
  assign if_pc_o     = inflight_pc_q;
  assign if_valid_o  = inflight_v_q & ~kill;
  assign fault_o     = fault_q;

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch_q;
  logic [15:0] perf_kill_q;
  logic [15:0] perf_stall_q;
  logic        stall_event;

  assign stall_event = (state_q == RUN) & stall_i & ~redirect_v_i;

  // Saturating event counters: launches, accepted redirects, stalled RUN cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= '0;
      perf_kill_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (launch_en)   perf_fetch_q <= sat_inc16(perf_fetch_q);
      if (kill)        perf_kill_q  <= sat_inc16(perf_kill_q);
      if (stall_event) perf_stall_q <= sat_inc16(perf_stall_q);
    end
  end

  assign perf_fetch_o = perf_fetch_q;
  assign perf_kill_o  = perf_kill_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: cycle-by-cycle vector table plus
// hand-written reset sequences. A simple synchronous memory model returns
// a word derived from the address one cycle after each launch.
module tb_fetch_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_v = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic [15:0] imem_addr;
  logic        imem_en;
  logic        imem_kill;
  logic [15:0] imem_rdata = '0;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_valid;
  logic        fault;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch, perf_kill, perf_stall;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ADDR_W(16), .INSTR_W(16), .MEM_DEPTH(256), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall_i(stall),
    .redirect_v_i(redirect_v),
    .redirect_pc_i(redirect_pc),
    .halt_i(halt),
    .imem_addr_o(imem_addr),
    .imem_en_o(imem_en),
    .imem_kill_o(imem_kill),
    .imem_instr_i(imem_rdata),
    .if_instr_o(if_instr),
    .if_pc_o(if_pc),
    .if_valid_o(if_valid),
`ifdef FETCH_PERF_EN
    .perf_fetch_o(perf_fetch),
    .perf_kill_o(perf_kill),
    .perf_stall_o(perf_stall),
`endif
    .fault_o(fault)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a < 16'd256) ? {a[7:0], ~a[7:0]} : 16'hDEAD;
  endfunction

  // Synchronous memory: output changes only on a launched read.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_word(imem_addr);
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic        halt;
    logic [15:0] addr;
    logic        en;
    logic        kill;
    logic        valid;
    logic [15:0] pc;
    logic        fault;
  } vec_t;

  localparam int NVEC = 28;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic s, input logic r, input logic [15:0] rp, input logic h,
                              input logic [15:0] a, input logic e, input logic k, input logic v,
                              input logic [15:0] p, input logic f);
    vec_t t;
    t.stall = s; t.redir = r; t.rpc = rp; t.halt = h;
    t.addr = a; t.en = e; t.kill = k; t.valid = v; t.pc = p; t.fault = f;
    return t;
  endfunction

  task automatic check_outputs(input int idx, input logic [15:0] a, input logic e, input logic k,
                               input logic v, input logic [15:0] p, input logic f);
    chk("addr",  idx, 32'(imem_addr), 32'(a));
    chk("en",    idx, 32'(imem_en),   32'(e));
    chk("kill",  idx, 32'(imem_kill), 32'(k));
    chk("valid", idx, 32'(if_valid),  32'(v));
    chk("pc",    idx, 32'(if_pc),     32'(p));
    chk("fault", idx, 32'(fault),     32'(f));
    if (v) chk("instr", idx, 32'(if_instr), 32'(mem_word(p)));
  endtask

  initial begin
    //            st rd rpc      ht  addr     en kl vl pc       flt
    vecs[0]  = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h0000, 0);
    vecs[1]  = mk(0, 0, 16'h0000, 0, 16'h0001, 1, 0, 1, 16'h0000, 0);
    vecs[2]  = mk(0, 0, 16'h0000, 0, 16'h0002, 1, 0, 1, 16'h0001, 0);
    vecs[3]  = mk(0, 0, 16'h0000, 0, 16'h0003, 1, 0, 1, 16'h0002, 0);
    vecs[4]  = mk(0, 0, 16'h0000, 0, 16'h0004, 1, 0, 1, 16'h0003, 0);
    // stall three cycles with pc_q = 5
    vecs[5]  = mk(1, 0, 16'h0000, 0, 16'h0005, 0, 0, 1, 16'h0004, 0);
    vecs[6]  = mk(1, 0, 16'h0000, 0, 16'h0005, 0, 0, 1, 16'h0004, 0);
    vecs[7]  = mk(1, 0, 16'h0000, 0, 16'h0005, 0, 0, 1, 16'h0004, 0);
    vecs[8]  = mk(0, 0, 16'h0000, 0, 16'h0005, 1, 0, 1, 16'h0004, 0);
    vecs[9]  = mk(0, 0, 16'h0000, 0, 16'h0006, 1, 0, 1, 16'h0005, 0);
    // halt at pc_q = 7, idle in HALT (stall ignored), redirect to 2
    vecs[10] = mk(0, 0, 16'h0000, 1, 16'h0007, 0, 0, 1, 16'h0006, 0);
    vecs[11] = mk(0, 0, 16'h0000, 0, 16'h0007, 0, 0, 0, 16'h0006, 0);
    vecs[12] = mk(1, 0, 16'h0000, 0, 16'h0007, 0, 0, 0, 16'h0006, 0);
    vecs[13] = mk(0, 1, 16'h0002, 0, 16'h0007, 0, 1, 0, 16'h0006, 0);
    vecs[14] = mk(0, 0, 16'h0000, 0, 16'h0002, 1, 0, 0, 16'h0006, 0);
    vecs[15] = mk(0, 0, 16'h0000, 0, 16'h0003, 1, 0, 1, 16'h0002, 0);
    // redirect to 0x0A kills the in-flight word
    vecs[16] = mk(0, 1, 16'h000A, 0, 16'h0004, 0, 1, 0, 16'h0003, 0);
    vecs[17] = mk(0, 0, 16'h0000, 0, 16'h000A, 1, 0, 0, 16'h0003, 0);
    vecs[18] = mk(0, 0, 16'h0000, 0, 16'h000B, 1, 0, 1, 16'h000A, 0);
    // redirect + stall + halt together: redirect wins, stays in RUN
    vecs[19] = mk(1, 1, 16'h0020, 1, 16'h000C, 0, 1, 0, 16'h000B, 0);
    vecs[20] = mk(0, 0, 16'h0000, 0, 16'h0020, 1, 0, 0, 16'h000B, 0);
    vecs[21] = mk(0, 0, 16'h0000, 0, 16'h0021, 1, 0, 1, 16'h0020, 0);
    // last implemented word, then an out-of-range launch faults
    vecs[22] = mk(0, 1, 16'h00FF, 0, 16'h0022, 0, 1, 0, 16'h0021, 0);
    vecs[23] = mk(0, 0, 16'h0000, 0, 16'h00FF, 1, 0, 0, 16'h0021, 0);
    vecs[24] = mk(0, 0, 16'h0000, 0, 16'h0100, 0, 0, 1, 16'h00FF, 0);
    vecs[25] = mk(0, 0, 16'h0000, 0, 16'h0100, 0, 0, 0, 16'h00FF, 1);
    vecs[26] = mk(0, 1, 16'h0005, 0, 16'h0100, 0, 0, 0, 16'h00FF, 1);
    vecs[27] = mk(0, 0, 16'h0000, 0, 16'h0100, 0, 0, 0, 16'h00FF, 1);

    // Reset state while rst_n is low.
    #12;
    check_outputs(100, 16'h0000, 0, 0, 0, 16'h0000, 0);

    // BOOT cycle after release: no fetch.
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_outputs(101, 16'h0000, 0, 0, 0, 16'h0000, 0);

    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk); #1;
      stall       = vecs[i].stall;
      redirect_v  = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      halt        = vecs[i].halt;
      @(negedge clk);
      check_outputs(i, vecs[i].addr, vecs[i].en, vecs[i].kill, vecs[i].valid, vecs[i].pc, vecs[i].fault);
    end

`ifdef FETCH_PERF_EN
    // launches: rows 0-4,8,9,14,15,17,18,20,21,23 = 14; redirects: 13,16,19,22 = 4; stalls: 5-7 = 3
    chk("perf_fetch", 200, 32'(perf_fetch), 32'd14);
    chk("perf_kill",  200, 32'(perf_kill),  32'd4);
    chk("perf_stall", 200, 32'(perf_stall), 32'd3);
`endif

    // Reset while in FAULT clears the sticky fault immediately.
    @(posedge clk); #1;
    stall = 1'b0; redirect_v = 1'b0; redirect_pc = '0; halt = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_outputs(102, 16'h0000, 0, 0, 0, 16'h0000, 0);

    // Restart: BOOT, then addresses 0..3.
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_outputs(103, 16'h0000, 0, 0, 0, 16'h0000, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_outputs(110 + k, 16'(k), 1, 0, (k > 0), (k > 0) ? 16'(k - 1) : 16'h0000, 0);
    end

    // Asynchronous reset mid-cycle while fetching: outputs drop at once.
    #1 rst_n = 1'b0;
    #1 check_outputs(120, 16'h0000, 0, 0, 0, 16'h0000, 0);

    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_outputs(121, 16'h0000, 0, 0, 0, 16'h0000, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
